// File: rtl/fsm_trace_monitor_if.sv
// Trace stream between fsm_trace_monitor and its consumer.
// The monitor drives entries (valid/data/id); the consumer returns ready.
interface fsm_trace_monitor_if #(
  parameter int DATA_W = 24
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [7:0]        m_id;

  modport master (
    output m_valid,
    output m_data,
    output m_id,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_id,
    output m_ready
  );
endinterface

// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor
// Passive observer of a state vector. While capture is enabled, every change
// of state_i is recorded as {ts, prev_state, new_state} in a show-ahead trace
// FIFO that a consumer drains over a valid/ready stream. Events that find the
// FIFO full (and no pop in the same cycle) are dropped and counted.
module fsm_trace_monitor #(
  parameter int STATE_W = 4,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8,
  parameter int NAME    = 0
) (
  input  logic                     aclk,
  input  logic                     srst,
  input  logic [STATE_W-1:0]       state_i,
  input  logic                     trace_en,
  input  logic                     clear_i,
  fsm_trace_monitor_if.master      m,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = TS_W + 2 * STATE_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // capture FSM
  state_t             state_r;
  state_t             state_nxt_s;
  logic               capture_s;
  logic               load_prev_s;

  // event path
  logic [TS_W-1:0]    ts_r;
  logic [STATE_W-1:0] prev_r;
  logic               event_s;
  logic [DW-1:0]      entry_s;

  // FIFO
  logic [DW-1:0]      mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW-1:0]      rd_ptr_nxt_s;
  logic [LW-1:0]      level_r;
  logic [LW-1:0]      level_nxt_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [DW-1:0]      head_nxt_s;
  logic               m_valid_r;
  logic [DW-1:0]      m_data_r;

  // drop bookkeeping
  logic               overflow_r;
  logic [7:0]         drop_cnt_r;

  // Capture FSM state register
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture FSM next-state: RUN follows trace_en
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (trace_en) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (trace_en) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Capture FSM outputs: the enable edge only arms prev, RUN captures and tracks
  always_comb begin
    capture_s   = 1'b0;
    load_prev_s = 1'b0;
    case (state_r)
      IDLE: begin
        capture_s   = 1'b0;
        load_prev_s = trace_en;
      end
      RUN: begin
        capture_s   = trace_en;
        load_prev_s = 1'b1;
      end
      default: begin
        capture_s   = 1'b0;
        load_prev_s = 1'b0;
      end
    endcase
  end

  // Free-running timestamp, restarts at zero after reset and wraps silently
  always_ff @(posedge aclk) begin
    if (srst) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
    end
  end

  // Previous-state register used for change detection
  always_ff @(posedge aclk) begin
    if (srst) begin
      prev_r <= {STATE_W{1'b0}};
    end else if (load_prev_s) begin
      prev_r <= state_i;
    end else begin
      prev_r <= prev_r;
    end
  end

  // Event detection, push/pop/drop decisions
  always_comb begin
    event_s = capture_s && (state_i != prev_r);
    entry_s = {ts_r, prev_r, state_i};
    pop_s   = m_valid_r && m.m_ready;
    // A simultaneous pop frees a slot even when the FIFO is full
    push_s  = event_s && ((level_r < LW'(DEPTH)) || pop_s);
    drop_s  = event_s && !push_s;
  end

  // Next occupancy and read pointer
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   level_nxt_s = level_r - {{(LW-1){1'b0}}, 1'b1};
      default: level_nxt_s = level_r;
    endcase
    if (pop_s) rd_ptr_nxt_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    else       rd_ptr_nxt_s = rd_ptr_r;
  end

  // Head of the FIFO after this edge; the pushed entry becomes head only
  // when it will be the sole occupant
  always_comb begin
    head_nxt_s = m_data_r;
    if (push_s && (level_nxt_s == {{(LW-1){1'b0}}, 1'b1})) begin
      head_nxt_s = entry_s;
    end else if (level_nxt_s != {LW{1'b0}}) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else begin
      head_nxt_s = m_data_r;
    end
  end

  // FIFO storage
  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and registered show-ahead output
  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {LW{1'b0}};
      m_valid_r <= 1'b0;
      m_data_r  <= {DW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      else        wr_ptr_r <= wr_ptr_r;
      rd_ptr_r  <= rd_ptr_nxt_s;
      level_r   <= level_nxt_s;
      m_valid_r <= (level_nxt_s != {LW{1'b0}});
      m_data_r  <= head_nxt_s;
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge aclk) begin
    if (srst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clear_i)                    drop_cnt_r <= 8'd1;
      else if (drop_cnt_r == 8'd255)  drop_cnt_r <= drop_cnt_r;
      else                            drop_cnt_r <= drop_cnt_r + 8'd1;
    end else if (clear_i) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      overflow_r <= overflow_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign m.m_valid = m_valid_r;
  assign m.m_data  = m_data_r;
  assign m.m_id    = 8'(NAME);
  assign level     = level_r;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/fsm_trace_monitor.md
# fsm_trace_monitor

Passive observer for the example state machines: it watches a state vector, detects every state change, and records it with a timestamp and the old and new state values in a small trace FIFO. A log or testbench consumer then drains the trace over a valid/ready stream. It sits beside any `fsm` instance as the reading end of that block's state activity. It is synthesizable so it can also stay in silicon as a debug tap.

## Interface
Parameters:
- `STATE_W`, 4: width of the observed state vector.
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 8: trace FIFO entries; power of two, ≥2.
- `NAME`, 0: instance tag; appears in `m_id` and nowhere else.

Ports:
- `aclk`  in  1  clock; everything is on the rising edge.
- `srst`  in  1  reset, synchronous, active-high.
- `state_i`  in  STATE_W  observed state.
- `trace_en`  in  1  enables capture.
- `clear_i`  in  1  clears `overflow` and `drop_cnt`.
- `m_valid`  out  1  trace entry available.
- `m_ready`  in  1  consumer accepts the entry.
- `m_data`  out  TS_W+2*STATE_W  entry fields, high to low: {ts, prev_state, new_state}.
- `m_id`  out  8  constant `NAME[7:0]`.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; an event was dropped.
- `drop_cnt`  out  8  dropped events, saturating.

## Operation
- **Timestamp `ts`:** free-running counter. It is 0 in the cycle after reset, increments by 1 every cycle and wraps from 2^TS_W−1 to 0. An event records the `ts` value of the cycle in which the change is sampled.
- **FSM states:**
  - IDLE: not capturing.
  - RUN: capturing.
- **Transitions:**
  - IDLE→RUN when `trace_en`=1. The same edge loads `prev_q`←`state_i`; no event is generated.
  - RUN→IDLE when `trace_en`=0. FIFO contents are kept and stay drainable.
  - RUN stays in RUN while `trace_en`=1.
- **Event:** in RUN with `trace_en`=1 and `state_i`≠`prev_q`. The entry is {ts, prev_q, state_i}, and `prev_q`←`state_i` on the same edge. Every cycle in RUN updates `prev_q`.
- **Push rule:** an event is written if `level`<DEPTH, or if a pop happens in the same cycle (`m_valid`&&`m_ready`).
  - Otherwise the event is dropped: `overflow`←1 and `drop_cnt`←`drop_cnt`+1, saturating at 255.
- **Pop:** happens when `m_valid`&&`m_ready`. The FIFO is show-ahead, so `m_data` always presents the oldest entry while `m_valid`=1.
- **`level`:** +1 on push only, −1 on pop only, unchanged on push+pop.
- **`clear_i`:** zeroes `overflow` and `drop_cnt` on the next edge. If a drop happens in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.
- **Reset:** `srst`=1 has priority over everything.

## Timing
- **Reset values:**
  - `m_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
  - `m_data`=0, `ts`=0, `prev_q`=0.
  - FSM in IDLE.
  - `m_id` is constant.
- **Latency:** a change sampled on edge N gives `m_valid`=1 and `m_data` = that entry after edge N when the FIFO was empty.
- **Handshake:**
  - `m_valid` never drops without a pop.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
  - `m_ready` may be high while `m_valid`=0; it has no effect.
- **Full FIFO:** push+pop in the same cycle keeps `level`=DEPTH and loses nothing.
- **Empty FIFO:** a pop attempt is ignored.
- **Pointer wrap:** read and write pointers wrap mod DEPTH. A full/empty distinction uses the extra `level` bit.
- **Reset mid-drain:** the FIFO is flushed. `m_valid`=0 from the first edge with `srst`=1; there are no partial entries.
- **Timestamp wrap:** `ts` wraps silently; it has no flag.

## Test plan
- **Basic capture:** reset, set `trace_en`=1 at ts=5 with `state_i`=2, then `state_i`=3 at ts=8, `m_ready`=1 → one entry {8,2,3}, `m_valid`=1 the cycle after, `level` 1→0.
- **Enable edge:** `trace_en`=1 while `state_i` is already 7 → no entry. Change to 7→1 → entry {ts,7,1}.
- **Overflow:** DEPTH=8, `m_ready`=0, 10 state changes → `level`=8, `overflow`=1, `drop_cnt`=2. Draining returns the first 8 entries in order. `clear_i` → `drop_cnt`=0, `overflow`=0.
- **Full with push and pop:** full FIFO, a change in the same cycle as a pop → `level` stays 8, `drop_cnt` is unchanged, and the new entry is read last.
- **Backpressure:** toggle `m_ready` randomly → `m_data` is stable while stalled, and the entry sequence matches a reference queue.
- **Reset mid-operation:** `level`=5 with `srst` pulsed → `m_valid`=0 and `level`=0 after the edge; `ts` restarts at 0. A change without re-enable gives no entry.
